// File: rtl/bm_cam_array.sv
`default_nettype none
// ============================================================================
//  Module      : bm_cam_array
//  Description : Binary-match CAM. Each entry is a set of 64x1 LUTRAMs, one
//                per 6-bit key slice, plus a valid flag. Searches are single
//                cycle with a registered result; updates sweep all 64
//                addresses of the target entry before committing.
//  Revision    : 1.0 - initial release
// ============================================================================
module bm_cam_array #(
    parameter int KEY_WIDTH = 24,
    parameter int ENTRIES   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       search_valid,
    input  logic [KEY_WIDTH-1:0]       search_key,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx,
    input  logic [KEY_WIDTH-1:0]       upd_key,
    input  logic                       upd_en,
    output logic                       upd_done,
    output logic                       match_valid,
    output logic [ENTRIES-1:0]         match_vec,
    output logic                       match_hit,
    output logic [$clog2(ENTRIES)-1:0] match_idx
);

    localparam int IDXW   = $clog2(ENTRIES);
    localparam int SLICES = KEY_WIDTH / 6;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SWEEP  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;
    localparam logic [5:0] c_CNT_LAST  = 6'd63;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_accept;
    logic [5:0]           r_cnt;
    logic [IDXW-1:0]      r_idx;
    logic [KEY_WIDTH-1:0] r_key;
    logic                 r_en;
    logic [ENTRIES-1:0]   r_valid;

    // Slice RAMs: contents are deliberately not reset.
    logic [63:0]          r_ram [ENTRIES][SLICES];

    logic [ENTRIES-1:0]   w_vec;
    logic [IDXW-1:0]      w_idx;
    logic                 r_match_valid;
    logic [ENTRIES-1:0]   r_match_vec;
    logic                 r_match_hit;
    logic [IDXW-1:0]      r_match_idx;

    // Next-state logic of the update engine; requests are only taken in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (upd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_SWEEP;
                end
            end
            c_ST_SWEEP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign upd_ready = (r_state == c_ST_IDLE);
    assign upd_done  = (r_state == c_ST_COMMIT) && !rst;

    // Update engine state: latch the request, invalidate the entry while its
    // RAM is rewritten, and publish the new valid flag on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 6'd0;
            r_idx   <= '0;
            r_key   <= '0;
            r_en    <= 1'b0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx            <= upd_idx;
                r_key            <= upd_key;
                r_en             <= upd_en;
                r_cnt            <= 6'd0;
                r_valid[upd_idx] <= 1'b0;
            end else if (r_state == c_ST_SWEEP) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == c_ST_COMMIT) begin
                r_valid[r_idx] <= r_en;
            end
        end
    end

    // Sweep write: address cnt of each slice RAM is 1 only where it equals
    // that slice of the key (and only for a write, never for a delete).
    always_ff @(posedge clk) begin
        if (!rst && (r_state == c_ST_SWEEP)) begin
            for (int s = 0; s < SLICES; s++) begin
                r_ram[r_idx][s][r_cnt] <= (r_key[6*s +: 6] == r_cnt) && r_en;
            end
        end
    end

    // Per-entry hit: valid flag ANDed with the addressed bit of every slice.
    always_comb begin
        w_vec = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_vec[e] = r_valid[e];
            for (int s = 0; s < SLICES; s++) begin
                w_vec[e] = w_vec[e] & r_ram[e][s][search_key[6*s +: 6]];
            end
        end
    end

    // Priority encoder: lowest-numbered hit wins, 0 when nothing hits.
    always_comb begin
        w_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (w_vec[e]) begin
                w_idx = IDXW'(e);
            end
        end
    end

    // Result register: one-cycle search latency, zeroed when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_valid <= 1'b0;
            r_match_vec   <= '0;
            r_match_hit   <= 1'b0;
            r_match_idx   <= '0;
        end else begin
            r_match_valid <= search_valid;
            r_match_vec   <= search_valid ? w_vec : '0;
            r_match_hit   <= search_valid && (|w_vec);
            r_match_idx   <= search_valid ? w_idx : '0;
        end
    end

    assign match_valid = r_match_valid;
    assign match_vec   = r_match_vec;
    assign match_hit   = r_match_hit;
    assign match_idx   = r_match_idx;

endmodule
`default_nettype wire

// File: tb/tb_bm_cam_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bm_cam_array
//  Description : Self-checking bench for bm_cam_array (KEY_WIDTH=24,
//                ENTRIES=8). Table vectors plus hand-written update, delete
//                and reset-abort sequences with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bm_cam_array;

    logic        clk;
    logic        rst;
    logic        search_valid;
    logic [23:0] search_key;
    logic        upd_valid;
    logic        upd_ready;
    logic [2:0]  upd_idx;
    logic [23:0] upd_key;
    logic        upd_en;
    logic        upd_done;
    logic        match_valid;
    logic [7:0]  match_vec;
    logic        match_hit;
    logic [2:0]  match_idx;

    bm_cam_array #(
        .KEY_WIDTH (24),
        .ENTRIES   (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .search_valid (search_valid),
        .search_key   (search_key),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_key      (upd_key),
        .upd_en       (upd_en),
        .upd_done     (upd_done),
        .match_valid  (match_valid),
        .match_vec    (match_vec),
        .match_hit    (match_hit),
        .match_idx    (match_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       hit;
        logic [2:0] idx;
        logic [7:0] vec;
    } exp_t;

    typedef struct {
        int          phase;
        logic        sv;
        logic [23:0] key;
        logic [7:0]  exp;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[19];
    logic        mvalid[8];
    logic [23:0] mkey[8];
    int          n_checks;
    int          n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_vec(input logic [23:0] k);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = mvalid[i] && (mkey[i] == k);
        return v;
    endfunction

    // Push the expected result of the search driven this cycle, clock once,
    // then compare the registered result against the scoreboard head.
    task automatic tick(input string nm, input logic [7:0] expv);
        exp_t e;
        e.v   = search_valid && !rst;
        e.vec = e.v ? expv : 8'h00;
        e.hit = |e.vec;
        e.idx = 3'd0;
        for (int i = 7; i >= 0; i--) if (e.vec[i]) e.idx = 3'(i);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check(nm, 32'({match_valid, match_hit, match_idx, match_vec}), 32'(e));
    endtask

    task automatic run_table(input int ph);
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].phase == ph) begin
                search_valid = tbl[i].sv;
                search_key   = tbl[i].key;
                tick($sformatf("table_p%0d_%0d", ph, i), tbl[i].exp);
            end
        end
        search_valid = 1'b1;
    endtask

    // Full update with a search of skey every cycle; optionally fires a
    // stray request ten cycles after acceptance, which must be ignored.
    task automatic write_entry(input logic [2:0] idx, input logic [23:0] key, input logic en,
                               input logic [23:0] skey, input bit pulse);
        int ready_low;
        int done_pos;
        check("accept_ready", 32'(upd_ready), 32'd1);
        upd_valid    = 1'b1;
        upd_idx      = idx;
        upd_key      = key;
        upd_en       = en;
        search_valid = 1'b1;
        search_key   = skey;
        tick("accept_search", model_vec(skey));
        mvalid[idx] = 1'b0;
        upd_valid   = 1'b0;
        ready_low   = 0;
        done_pos    = 0;
        for (int c = 1; c <= 200 && upd_ready == 1'b0; c++) begin
            if (upd_done) done_pos = c;
            ready_low++;
            if (pulse && c == 10) begin
                upd_valid = 1'b1;
                upd_idx   = 3'd4;
                upd_key   = 24'h123456;
                upd_en    = 1'b1;
            end else begin
                upd_valid = 1'b0;
            end
            tick("during_update", model_vec(skey));
        end
        upd_valid   = 1'b0;
        mvalid[idx] = en;
        mkey[idx]   = key;
        check("ready_low_cycles", 32'(ready_low), 32'd65);
        check("done_cycle", 32'(done_pos), 32'd65);
        check("done_single_pulse", 32'(upd_done), 32'd0);
        tick("first_search_after", model_vec(skey));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl = '{
            '{1, 1'b1, 24'h123456, 8'h08}, '{1, 1'b1, 24'h123457, 8'h00},
            '{1, 1'b0, 24'h123456, 8'h00}, '{1, 1'b1, 24'h000000, 8'h00},
            '{2, 1'b1, 24'hABCDEF, 8'h22}, '{2, 1'b1, 24'h123456, 8'h08},
            '{2, 1'b1, 24'hABCDEE, 8'h00},
            '{3, 1'b1, 24'h00003F, 8'h05}, '{3, 1'b1, 24'h00003E, 8'h00},
            '{4, 1'b1, 24'h123456, 8'h00}, '{4, 1'b1, 24'hABCDEF, 8'h22},
            '{4, 1'b1, 24'h00003F, 8'h05},
            '{5, 1'b1, 24'hABCDEF, 8'h00}, '{5, 1'b1, 24'h00003F, 8'h00},
            '{5, 1'b1, 24'h123456, 8'h00},
            '{6, 1'b1, 24'h123456, 8'h08}, '{6, 1'b1, 24'hABCDEF, 8'h00},
            '{6, 1'b0, 24'hABCDEF, 8'h00}, '{6, 1'b1, 24'h000000, 8'h00}
        };
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mkey[i]   = 24'h0;
        end
        rst          = 1'b1;
        search_valid = 1'b1;
        search_key   = 24'h123456;
        upd_valid    = 1'b1;
        upd_idx      = 3'd2;
        upd_key      = 24'h123456;
        upd_en       = 1'b1;

        // Reset has priority over both search and update requests.
        repeat (3) tick("reset_search", 8'hFF);
        check("reset_done", 32'(upd_done), 32'd0);
        rst       = 1'b0;
        upd_valid = 1'b0;
        check("reset_ready", 32'(upd_ready), 32'd1);
        search_key = 24'h000000;
        tick("post_reset_search", 8'h00);

        write_entry(3'd3, 24'h123456, 1'b1, 24'h123456, 1'b0);
        run_table(1);

        write_entry(3'd5, 24'hABCDEF, 1'b1, 24'hABCDEF, 1'b0);
        write_entry(3'd1, 24'hABCDEF, 1'b1, 24'hABCDEF, 1'b0);
        run_table(2);

        write_entry(3'd0, 24'h00003F, 1'b1, 24'h00003F, 1'b0);
        write_entry(3'd2, 24'h00003F, 1'b1, 24'h00003F, 1'b0);
        run_table(3);

        write_entry(3'd3, 24'h123456, 1'b0, 24'h123456, 1'b1);
        run_table(4);

        // Reset in the middle of a sweep aborts the update.
        upd_valid  = 1'b1;
        upd_idx    = 3'd3;
        upd_key    = 24'h123456;
        upd_en     = 1'b1;
        search_key = 24'h123456;
        tick("abort_accept", model_vec(24'h123456));
        mvalid[3] = 1'b0;
        upd_valid = 1'b0;
        repeat (29) tick("abort_sweep", model_vec(24'h123456));
        rst = 1'b1;
        tick("abort_reset", 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        check("abort_ready", 32'(upd_ready), 32'd1);
        check("abort_done", 32'(upd_done), 32'd0);
        run_table(5);

        write_entry(3'd3, 24'h123456, 1'b1, 24'h123456, 1'b0);
        run_table(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
